// File: rtl/merged_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// merged_mem_ctrl_pkg
//   Shared definitions for the merged-memory-bus slave controller:
//   FSM state encoding, access-type encoding and a range-check helper.
// ---------------------------------------------------------------------------
package merged_mem_ctrl_pkg;

  // Controller FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Access type latched at the start of an access.
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 4;   // wait-state counter width (0..15)

  // True when a word index (byte address [31:2]) falls inside the SRAM.
  function automatic logic word_in_range(input logic [29:0] word,
                                         input int unsigned words);
    return ({2'b00, word} < words);
  endfunction

endpackage

// File: rtl/merged_mem_ctrl.sv
// ---------------------------------------------------------------------------
// merged_mem_ctrl
//   Slave controller on the merged instruction/data memory bus. Converts
//   held-level rd/wr requests from the arbiter into single accesses on an
//   external single-port synchronous SRAM (1-cycle read latency), with
//   programmable wait states before the SRAM strobe and a one-cycle ready
//   pulse per completed access. An access is abandoned if the arbiter
//   changes or withdraws its request before completion.
//
// Parameters
//   MEM_WORDS    SRAM depth in 32-bit words; word index = addr[AW+1:2]
//   WAIT_STATES  idle cycles inserted before the SRAM strobe (0..15)
//
// Ports
//   clk_i              clock, rising edge
//   rst_i              asynchronous reset, active low
//   merged_mem_rd_i    read request, held until ready or withdrawn
//   merged_mem_wr_i    write request (wins when rd is also high)
//   merged_mem_addr_i  byte address, bits [1:0] ignored
//   merged_mem_data_i  write data
//   merged_mem_ready_o one-cycle completion pulse
//   merged_mem_data_o  read data, valid while ready is high
//   sram_en_o          SRAM strobe
//   sram_we_o          SRAM write enable (only high with sram_en_o)
//   sram_addr_o        SRAM word address
//   sram_wdata_o       SRAM write data
//   sram_rdata_i       SRAM read data, valid the cycle after a read strobe
//   addr_err_o         pulses with ready when the address is out of range
//   busy_o             controller is not idle
// ---------------------------------------------------------------------------
module merged_mem_ctrl
  import merged_mem_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 4096,
  parameter int unsigned WAIT_STATES = 0,
  localparam int unsigned AW         = $clog2(MEM_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              merged_mem_rd_i,
  input  logic              merged_mem_wr_i,
  input  logic [31:0]       merged_mem_addr_i,
  input  logic [31:0]       merged_mem_data_i,
  output logic              merged_mem_ready_o,
  output logic [31:0]       merged_mem_data_o,
  output logic              sram_en_o,
  output logic              sram_we_o,
  output logic [AW-1:0]     sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i,
  output logic              addr_err_o,
  output logic              busy_o
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  op_t                 op_q;
  logic [29:0]         word_q;    // latched byte address [31:2]
  logic [DATA_W-1:0]   wdata_q;

  op_t                 op_cur;
  logic                req;
  logic                match;
  logic                in_range;
  logic                unused_addr_lsb;

  // Byte-lane bits never take part in an access.
  assign unused_addr_lsb = ^merged_mem_addr_i[1:0];

  assign req      = merged_mem_rd_i | merged_mem_wr_i;
  assign op_cur   = merged_mem_wr_i ? OP_WR : OP_RD;
  assign match    = req && (op_q == op_cur) && (word_q == merged_mem_addr_i[31:2]);
  assign in_range = word_in_range(word_q, MEM_WORDS);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      op_q    <= OP_RD;
      word_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            op_q    <= op_cur;
            word_q  <= merged_mem_addr_i[31:2];
            wdata_q <= merged_mem_data_i;
            cnt     <= WAIT_INIT;
            state   <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          if (!match) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          state <= match ? ST_RESP : ST_IDLE;
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The strobe is gated by the live request so that an access withdrawn in
  // the ACCESS cycle never reaches the SRAM; address and data come from the
  // latched copies only.
  assign sram_en_o    = (state == ST_ACCESS) && match && in_range;
  assign sram_we_o    = sram_en_o && (op_q == OP_WR);
  assign sram_addr_o  = word_q[AW-1:0];
  assign sram_wdata_o = wdata_q;

  // A request that changes during RESP gets no ready; a write has already
  // been committed and the arbiter's reissue simply repeats it.
  assign merged_mem_ready_o = (state == ST_RESP) && match;
  assign merged_mem_data_o  = ((state == ST_RESP) && (op_q == OP_RD) && in_range)
                              ? sram_rdata_i : '0;
  assign addr_err_o         = merged_mem_ready_o && !in_range;
  assign busy_o             = (state != ST_IDLE);

endmodule

// File: tb/tb_merged_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_merged_mem_ctrl
//   Two controllers side by side: instance 0 with no wait states and a
//   1024-word SRAM, instance 1 with three wait states and a 4096-word SRAM.
//   Each has its own behavioural SRAM. Expected results come from a
//   transaction-level memory model (associative array) and the latency rule
//   ready = request + 2 + wait states.
// ---------------------------------------------------------------------------
module tb_merged_mem_ctrl;

  localparam int unsigned WS0 = 0;
  localparam int unsigned MW0 = 1024;
  localparam int unsigned WS1 = 3;
  localparam int unsigned MW1 = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ready [2];
  logic [31:0] dout  [2];
  logic        err   [2];
  logic        busy  [2];
  logic        en    [2];
  logic        we    [2];
  logic [31:0] swdata[2];
  logic [31:0] srdata[2];
  logic [9:0]  saddr0;
  logic [11:0] saddr1;

  merged_mem_ctrl #(.MEM_WORDS(MW0), .WAIT_STATES(WS0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n),
    .merged_mem_rd_i(rd[0]), .merged_mem_wr_i(wr[0]),
    .merged_mem_addr_i(addr[0]), .merged_mem_data_i(wdata[0]),
    .merged_mem_ready_o(ready[0]), .merged_mem_data_o(dout[0]),
    .sram_en_o(en[0]), .sram_we_o(we[0]), .sram_addr_o(saddr0),
    .sram_wdata_o(swdata[0]), .sram_rdata_i(srdata[0]),
    .addr_err_o(err[0]), .busy_o(busy[0])
  );

  merged_mem_ctrl #(.MEM_WORDS(MW1), .WAIT_STATES(WS1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n),
    .merged_mem_rd_i(rd[1]), .merged_mem_wr_i(wr[1]),
    .merged_mem_addr_i(addr[1]), .merged_mem_data_i(wdata[1]),
    .merged_mem_ready_o(ready[1]), .merged_mem_data_o(dout[1]),
    .sram_en_o(en[1]), .sram_we_o(we[1]), .sram_addr_o(saddr1),
    .sram_wdata_o(swdata[1]), .sram_rdata_i(srdata[1]),
    .addr_err_o(err[1]), .busy_o(busy[1])
  );

  // Behavioural single-port synchronous SRAMs, 1-cycle read latency.
  logic [31:0] mem0 [MW0];
  logic [31:0] mem1 [MW1];

  always @(posedge clk) begin
    if (en[0] === 1'b1) begin
      if (we[0] === 1'b1) mem0[saddr0] <= swdata[0];
      else                srdata[0]    <= mem0[saddr0];
    end
    if (en[1] === 1'b1) begin
      if (we[1] === 1'b1) mem1[saddr1] <= swdata[1];
      else                srdata[1]    <= mem1[saddr1];
    end
  end

  // Strobe / ready pulse counters, sampled mid-cycle.
  int strobe_cnt[2] = '{0, 0};
  int ready_cnt [2] = '{0, 0};
  always @(negedge clk) begin
    if (en[0] === 1'b1)    strobe_cnt[0] <= strobe_cnt[0] + 1;
    if (en[1] === 1'b1)    strobe_cnt[1] <= strobe_cnt[1] + 1;
    if (ready[0] === 1'b1) ready_cnt[0]  <= ready_cnt[0] + 1;
    if (ready[1] === 1'b1) ready_cnt[1]  <= ready_cnt[1] + 1;
  end

  // Reference model: memory contents keyed by instance*65536 + word.
  logic [31:0] ref_mem [int unsigned];
  int unsigned wq0[$];
  int unsigned wq1[$];
  int exp_strobes[2] = '{0, 0};
  int exp_readies[2] = '{0, 0};

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k, input int n);
    rd[k] = 1'b0;
    wr[k] = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_quiet(input int k, input string tag);
    check({tag, "_ready"}, 32'(ready[k]), 32'd0);
    check({tag, "_data"},  dout[k],       32'd0);
    check({tag, "_err"},   32'(err[k]),   32'd0);
    check({tag, "_busy"},  32'(busy[k]),  32'd0);
    check({tag, "_en"},    32'(en[k]),    32'd0);
    check({tag, "_we"},    32'(we[k]),    32'd0);
    check({tag, "_saddr"}, (k == 0) ? 32'(saddr0) : 32'(saddr1), 32'd0);
    check({tag, "_swd"},   swdata[k],     32'd0);
  endtask

  // One complete access from the arbiter's point of view. Inputs change
  // just after a rising edge; the request is left held afterwards, so the
  // caller either starts the next access at once or withdraws it.
  task automatic do_access(input int k, input bit is_wr, input logic [31:0] a,
                           input logic [31:0] d, input int exp_lat, input string tag);
    int unsigned words;
    int unsigned word;
    bit          inr;
    int          lat;
    int          s0;
    logic [31:0] exp_data;
    words = (k == 0) ? MW0 : MW1;
    word  = 32'(a[31:2]);
    inr   = (word < words);
    s0    = strobe_cnt[k];
    rd[k]    = is_wr ? 1'($urandom_range(0, 1)) : 1'b1;
    wr[k]    = is_wr;
    addr[k]  = a;
    wdata[k] = d;
    lat = 0;
    while (ready[k] !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    exp_data = 32'd0;
    if (!is_wr && inr) exp_data = ref_mem[k * 65536 + word];
    check({tag, "_data"}, dout[k], exp_data);
    check({tag, "_err"},  32'(err[k]), 32'(!inr));
    if (is_wr && inr) begin
      if (!ref_mem.exists(k * 65536 + word)) begin
        if (k == 0) wq0.push_back(word);
        else        wq1.push_back(word);
      end
      ref_mem[k * 65536 + word] = d;
    end
    exp_readies[k]++;
    if (inr) exp_strobes[k]++;
    tick();
    check({tag, "_pulse"},  32'(ready[k]), 32'd0);
    check({tag, "_strobe"}, 32'(strobe_cnt[k] - s0), 32'(inr));
  endtask

  initial begin
    int unsigned ws;
    int unsigned words;
    int unsigned word;
    bit          is_wr;
    logic [31:0] a;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    repeat (3) tick();
    check_quiet(0, "reset0");
    check_quiet(1, "reset1");
    rst_n = 1'b1;
    tick();

    // T1: zero wait states, write then read back.
    do_access(0, 1'b1, 32'h100, 32'hDEADBEEF, 2, "t1_wr");
    idle(0, 1);
    do_access(0, 1'b0, 32'h100, 32'h0, 2, "t1_rd");
    check("t1_value", ref_mem[32'h40], 32'hDEADBEEF);
    idle(0, 1);

    // T2: three wait states, latency 5.
    do_access(1, 1'b1, 32'h40, $urandom, 5, "t2_wr");
    idle(1, 1);
    do_access(1, 1'b0, 32'h40, 32'h0, 5, "t2_rd");
    idle(1, 1);

    // T3: read @0x200 switched to write @0x80 while waiting.
    rd[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h200; wdata[1] = '0;
    tick();
    tick();
    check("t3_busy", 32'(busy[1]), 32'd1);
    do_access(1, 1'b1, 32'h80, 32'hA5A5_0F0F, WS1 + 3, "t3_wr");
    idle(1, 1);
    do_access(1, 1'b0, 32'h80, 32'h0, 5, "t3_rd");
    idle(1, 1);

    // T4: out of range on the 1024-word instance, plus the last valid word.
    do_access(0, 1'b0, 32'h1000, 32'h0, 2, "t4_rd");
    idle(0, 1);
    do_access(0, 1'b1, 32'h1FFC, 32'h1234_5678, 2, "t4_wr_oor");
    idle(0, 1);
    do_access(0, 1'b1, 32'hFFC, 32'hCAFE_F00D, 2, "t4_wr_last");
    idle(0, 1);
    do_access(0, 1'b0, 32'hFFC, 32'h0, 2, "t4_rd_last");
    idle(0, 1);

    // T5: back-to-back reads with the request held throughout.
    do_access(0, 1'b1, 32'h0, 32'h1111_0000, 2, "t5_w0");
    do_access(0, 1'b1, 32'h4, 32'h2222_0004, 2, "t5_w4");
    do_access(0, 1'b0, 32'h0, 32'h0, 2, "t5_r0");
    do_access(0, 1'b0, 32'h4, 32'h0, 2, "t5_r4");
    do_access(0, 1'b0, 32'h4, 32'h0, 2, "t5_r4_again");
    idle(0, 1);

    // T6: reset asserted during the ACCESS cycle of a read.
    rd[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h100;
    tick();
    check("t6_en_live", 32'(en[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_quiet(0, "t6_reset");
    rd[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    do_access(0, 1'b0, 32'h100, 32'h0, 2, "t6_rd");
    idle(0, 1);

    // Randomised accesses on both instances.
    for (int k = 0; k < 2; k++) begin
      ws    = (k == 0) ? WS0 : WS1;
      words = (k == 0) ? MW0 : MW1;
      for (int n = 0; n < 60; n++) begin
        is_wr = 1'($urandom_range(0, 1));
        if (is_wr) begin
          word = $urandom_range(0, words + words / 8 - 1);
        end else if ($urandom_range(0, 3) == 0) begin
          word = $urandom_range(words, words + 200);
        end else if (k == 0) begin
          word = wq0[$urandom_range(0, wq0.size() - 1)];
        end else begin
          word = wq1[$urandom_range(0, wq1.size() - 1)];
        end
        a = (32'(word) << 2) | 32'($urandom_range(0, 3));
        do_access(k, is_wr, a, $urandom, int'(2 + ws), "rnd");
        if ($urandom_range(0, 2) != 0) idle(k, $urandom_range(1, 2));
      end
      idle(k, 2);
    end

    check("total_strobes0", 32'(strobe_cnt[0]), 32'(exp_strobes[0]));
    check("total_strobes1", 32'(strobe_cnt[1]), 32'(exp_strobes[1]));
    check("total_ready0",   32'(ready_cnt[0]),  32'(exp_readies[0]));
    check("total_ready1",   32'(ready_cnt[1]),  32'(exp_readies[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
